// File: rtl/tester_pkg.sv
// Shared definitions for the exhaustive combinational-block tester.
package tester_pkg;

  localparam int unsigned StateW = 3;
  localparam int unsigned TimerW = 4;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StApply  = 3'd1,
    StSettle = 3'd2,
    StSample = 3'd3,
    StDone   = 3'd4
  } state_e;

  // 3-input majority: bit k is the expected output for input vector k.
  localparam logic [7:0] DefaultExpected = 8'b1110_1000;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expired is high once the count has drained to zero.
module settle_timer
  import tester_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TimerW-1:0] load_val,
  output logic              expired
);

  logic [TimerW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/comb_vector_checker.sv
// Walks every input vector of a small combinational DUT, samples its output after a
// settle delay and checks it against a golden truth table.
module comb_vector_checker
  import tester_pkg::*;
#(
  parameter int unsigned             N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = DefaultExpected,
  parameter int unsigned             SETTLE   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int unsigned        NumVec   = 1 << N_IN;
  localparam logic [N_IN-1:0]    LastVec  = N_IN'(NumVec - 1);
  localparam logic [N_IN:0]      MaxFails = (N_IN + 1)'(NumVec);
  // The timer is loaded during APPLY, so SETTLE cycles need a load of SETTLE-1.
  localparam logic [TimerW-1:0]  SettleLoad = (SETTLE == 0) ? '0 : TimerW'(SETTLE - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     fail_count_q, fail_count_d;
  logic              ff_valid_q, ff_valid_d;
  logic [N_IN-1:0]   ff_vec_q, ff_vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timer_load;
  logic              timer_expired;

  settle_timer u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (SettleLoad),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    fail_count_d = fail_count_q;
    ff_valid_d   = ff_valid_q;
    ff_vec_d     = ff_vec_q;
    timer_load   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StApply;
          vec_d        = '0;
          fail_count_d = '0;
          ff_valid_d   = 1'b0;
          ff_vec_d     = '0;
        end
      end
      StApply: begin
        timer_load = 1'b1;
        state_d    = (SETTLE == 0) ? StSample : StSettle;
      end
      StSettle: begin
        if (timer_expired) begin
          state_d = StSample;
        end
      end
      StSample: begin
        if (dut_out != EXPECTED[vec_q]) begin
          if (fail_count_q != MaxFails) begin
            fail_count_d = fail_count_q + 1'b1;
          end
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_vec_d   = vec_q;
          end
        end
        if (vec_q == LastVec) begin
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d == StApply) || (state_d == StSettle) || (state_d == StSample);
    done_d = (state_d == StDone);
    pass_d = done_d && (fail_count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      fail_count_q <= '0;
      ff_valid_q   <= 1'b0;
      ff_vec_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      fail_count_q <= fail_count_d;
      ff_valid_q   <= ff_valid_d;
      ff_vec_q     <= ff_vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // The vector register doubles as the drive: it holds through SETTLE, SAMPLE and DONE.
  assign dut_in           = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail_count       = fail_count_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;

endmodule

// File: doc/comb_vector_checker.md
Name: comb_vector_checker

Overview:
- Synthesizable exhaustive tester for small combinational blocks such as `Combinational_Logic` (A,B,C -> F).
- It is the driving and checking end of that interface. It walks every input vector, waits a settle time, samples the DUT output and compares it to a parameterized truth table.
- It accumulates pass/fail results and reports the first failing vector.
- It sits beside the DUT in self-test wrappers and on FPGA bring-up builds.

Parameters:
- N_IN, 3, number of DUT inputs; vectors 0 .. 2^N_IN-1.
- EXPECTED, 8'b1110_1000, golden truth table; bit k = expected output for input vector k (default: 3-input majority). Width 2^N_IN.
- SETTLE, 1, idle cycles between driving a vector and sampling; legal range 0..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- dut_in  out  N_IN  vector driven to DUT, MSB = A, LSB = C for N_IN=3.
- dut_out  in  1  DUT output (F).
- busy  out  1  high while a run is in progress.
- done  out  1  high from end of run until next start or reset.
- pass  out  1  valid when done; 1 iff fail_count == 0.
- fail_count  out  N_IN+1  number of mismatching vectors; saturates at 2^N_IN.
- first_fail_valid  out  1  at least one mismatch seen this run.
- first_fail_vec  out  N_IN  index of first mismatching vector; 0 if none.

Behaviour:
- Reset (synchronous, active-high): all outputs are 0 and the state is IDLE. This includes dut_in, busy, done, pass, fail_count, first_fail_valid and first_fail_vec.
- Reset has priority over everything, including an in-flight run. The run is abandoned with no partial results kept.
- State machine: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> APPLY.
  - On entry, vec=0, fail_count=0 and first_fail_valid=0.
- APPLY (1 cycle): dut_in <= vec; busy=1. Next state is SETTLE if SETTLE>0, else SAMPLE.
- SETTLE: counts SETTLE cycles, then -> SAMPLE.
- SAMPLE (1 cycle): compare dut_out with EXPECTED[vec].
  - On mismatch: fail_count += 1.
  - If first_fail_valid=0, also set first_fail_vec=vec and first_fail_valid=1.
  - If vec == 2^N_IN-1 -> DONE; else vec += 1 -> APPLY.
- DONE: busy=0, done=1, pass=(fail_count==0). Outputs hold.
  - start=1 -> clear results and done, then APPLY with vec=0.
- start while busy is ignored and has no effect on the run.
- dut_in holds its last driven vector through SETTLE, SAMPLE and DONE. It returns to 0 only on reset.
- Timing:
  - Per vector: SETTLE+2 cycles.
  - The run is 2^N_IN*(SETTLE+2) cycles from the first APPLY.
  - done rises the cycle after the final SAMPLE. busy falls on that same edge.
- Vector counter wrap: no wrap occurs. The terminal compare on 2^N_IN-1 ends the run before any increment overflows.
- pass and first_fail_* are meaningful only while done=1. While busy they show live partial results.

Decomposition:
- Shared package `tester_pkg`: state encoding constants (IDLE=0, APPLY=1, SETTLE=2, SAMPLE=3, DONE=4), 3-bit state width, default EXPECTED constant.
- One sub-module `settle_timer`: loadable down-counter (4 bits). Ports: clk, reset, load, count value, expired flag. It is used by the SETTLE state.

Test Plan:
1. Correct DUT: majority DUT, defaults, start pulse.
   - done=1 exactly 24 cycles after the first APPLY.
   - pass=1, fail_count=0, first_fail_valid=0.
   - dut_in stepped 000..111.
2. Stuck-at-0 DUT: dut_out tied 0.
   - fail_count=4, pass=0.
   - first_fail_valid=1, first_fail_vec=3'b011.
3. Inverted DUT: dut_out = ~majority.
   - fail_count=8 (saturation bound), first_fail_vec=3'b000, pass=0.
4. Reset mid-run: assert reset during vector 5's SETTLE.
   - Next cycle all outputs are 0 and the state is IDLE.
   - A subsequent start yields a clean full run with pass=1.
5. Start handling:
   - start pulses while busy=1 leave the run length at 24 cycles and results unchanged.
   - start in DONE clears done the next cycle and reruns.
6. SETTLE=0 boundary: SAMPLE directly follows APPLY.
   - Run completes in 16 cycles.
   - Single-vector fault at vec=6 -> fail_count=1, first_fail_vec=3'b110.
